// File: rtl/seq_detector_param.sv
// Serial detector for a runtime-loaded PAT_W-bit pattern, with overlap/non-overlap mode and a saturating match counter.
// Latency: out and match_count update one edge after the completing bit. No backpressure: din is consumed whenever din_valid is high.
module seq_detector_param #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din_valid,
    input  logic             din,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic             count_clr,
    output logic             out,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);
    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]    FILL_ARM  = FW'(PAT_W - 1);
    localparam logic [FW-1:0]    FILL_FULL = FW'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic {ST_FILL, ST_ARMED} state_t;

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic               ovl_q, ovl_d;
    // Only the newest PAT_W-1 bits ever take part in the next comparison.
    logic [PAT_W-2:0]   hist_q, hist_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic               out_q, out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic [PAT_W-1:0]   cand;
    logic               hit;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        out_d   = 1'b0;
        hit     = 1'b0;
        cand    = {hist_q, din};

        if (cfg_load) begin
            pat_d   = cfg_pattern;
            ovl_d   = cfg_overlap;
            hist_d  = '0;
            fill_d  = '0;
            state_d = ST_FILL;
        end else if (din_valid) begin
            if (state_q == ST_FILL) begin
                hist_d = cand[PAT_W-2:0];
                fill_d = fill_q + 1'b1;
                if (fill_d == FILL_ARM) state_d = ST_ARMED;
            end else begin
                hit   = (cand == pat_q);
                out_d = hit;
                if (hit && !ovl_q) begin
                    hist_d  = '0;
                    fill_d  = '0;
                    state_d = ST_FILL;
                end else begin
                    hist_d = cand[PAT_W-2:0];
                    if (fill_q != FILL_FULL) fill_d = fill_q + 1'b1;
                end
            end
        end

        cnt_d = cnt_q;
        sat_d = sat_q;
        if (count_clr) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (hit) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            if (cnt_d == CNT_MAX) sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_FILL;
            pat_q   <= '0;
            ovl_q   <= 1'b1;
            hist_q  <= '0;
            fill_q  <= '0;
            out_q   <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    assign out         = out_q;
    assign match_count = cnt_q;
    assign count_sat   = sat_q;
endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param (PAT_W=4, CNT_W=2, pattern 1011).
module tb_seq_detector_param;
    logic       clk;
    logic       reset;
    logic       din_valid;
    logic       din;
    logic       cfg_load;
    logic [3:0] cfg_pattern;
    logic       cfg_overlap;
    logic       count_clr;
    logic       out;
    logic [1:0] match_count;
    logic       count_sat;

    int n_pass = 0;
    int n_total = 0;

    seq_detector_param #(.PAT_W(4), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
        .count_clr(count_clr), .out(out), .match_count(match_count), .count_sat(count_sat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string      name;
        logic       rst_n, ld, ovl, vld, d, clr;
        logic       e_out;
        logic [1:0] e_cnt;
        logic       e_sat;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string name, input logic rst_n, ld, ovl, vld, d, clr,
                       input logic e_out, input logic [1:0] e_cnt, input logic e_sat);
        vec_t v;
        v.name = name; v.rst_n = rst_n; v.ld = ld; v.ovl = ovl; v.vld = vld;
        v.d = d; v.clr = clr; v.e_out = e_out; v.e_cnt = e_cnt; v.e_sat = e_sat;
        tbl.push_back(v);
    endtask

    // Apply one cycle of inputs, then sample just after the edge that consumed them.
    task automatic step(input logic rst_n, ld, ovl, vld, d, clr);
        reset = rst_n; cfg_load = ld; cfg_overlap = ovl;
        din_valid = vld; din = d; count_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic e_out, input logic [1:0] e_cnt,
                         input logic e_sat);
        n_total++;
        if (out === e_out && match_count === e_cnt && count_sat === e_sat) n_pass++;
        else $display("FAIL %s: got out=%b cnt=%0d sat=%b, want out=%b cnt=%0d sat=%b",
                      name, out, match_count, count_sat, e_out, e_cnt, e_sat);
    endtask

    task automatic bit_in(input string name, input logic d, input logic e_out,
                          input logic [1:0] e_cnt, input logic e_sat);
        step(1'b1, 1'b0, 1'b0, 1'b1, d, 1'b0);
        check(name, e_out, e_cnt, e_sat);
    endtask

    logic [15:0] sat_bits;
    logic [15:0] sat_hits;

    initial begin
        reset = 1'b0; cfg_load = 1'b0; cfg_pattern = 4'b1011; cfg_overlap = 1'b0;
        din_valid = 1'b0; din = 1'b0; count_clr = 1'b0;

        //   name          rst ld ovl vld d clr | out cnt sat
        add("reset",       0, 0, 0, 0, 0, 0,   0, 2'd0, 0);
        add("ovl_load",    1, 1, 1, 0, 0, 0,   0, 2'd0, 0);
        add("ovl_b1",      1, 0, 0, 1, 1, 0,   0, 2'd0, 0);
        add("ovl_b2",      1, 0, 0, 1, 0, 0,   0, 2'd0, 0);
        add("ovl_b3",      1, 0, 0, 1, 1, 0,   0, 2'd0, 0);
        add("ovl_b4",      1, 0, 0, 1, 1, 0,   1, 2'd1, 0);
        add("ovl_b5",      1, 0, 0, 1, 0, 0,   0, 2'd1, 0);
        add("ovl_b6",      1, 0, 0, 1, 1, 0,   0, 2'd1, 0);
        add("ovl_b7",      1, 0, 0, 1, 1, 0,   1, 2'd2, 0);
        add("clr",         1, 0, 0, 0, 0, 1,   0, 2'd0, 0);
        add("nov_load",    1, 1, 0, 0, 0, 0,   0, 2'd0, 0);
        add("nov_b1",      1, 0, 0, 1, 1, 0,   0, 2'd0, 0);
        add("nov_b2",      1, 0, 0, 1, 0, 0,   0, 2'd0, 0);
        add("nov_b3",      1, 0, 0, 1, 1, 0,   0, 2'd0, 0);
        add("nov_b4",      1, 0, 0, 1, 1, 0,   1, 2'd1, 0);
        add("nov_b5",      1, 0, 0, 1, 0, 0,   0, 2'd1, 0);
        add("nov_b6",      1, 0, 0, 1, 1, 0,   0, 2'd1, 0);
        add("nov_b7",      1, 0, 0, 1, 1, 0,   0, 2'd1, 0);
        add("nov2_load",   1, 1, 0, 0, 0, 1,   0, 2'd0, 0);
        add("nov2_b1",     1, 0, 0, 1, 1, 0,   0, 2'd0, 0);
        add("nov2_b2",     1, 0, 0, 1, 0, 0,   0, 2'd0, 0);
        add("nov2_b3",     1, 0, 0, 1, 1, 0,   0, 2'd0, 0);
        add("nov2_b4",     1, 0, 0, 1, 1, 0,   1, 2'd1, 0);
        add("nov2_b5",     1, 0, 0, 1, 1, 0,   0, 2'd1, 0);
        add("nov2_b6",     1, 0, 0, 1, 0, 0,   0, 2'd1, 0);
        add("nov2_b7",     1, 0, 0, 1, 1, 0,   0, 2'd1, 0);
        add("nov2_b8",     1, 0, 0, 1, 1, 0,   1, 2'd2, 0);
        add("gate_load",   1, 1, 1, 0, 0, 1,   0, 2'd0, 0);
        add("gate_b1",     1, 0, 0, 1, 1, 0,   0, 2'd0, 0);
        add("gate_b2",     1, 0, 0, 1, 0, 0,   0, 2'd0, 0);
        add("gate_idle1",  1, 0, 0, 0, 1, 0,   0, 2'd0, 0);
        add("gate_idle2",  1, 0, 0, 0, 1, 0,   0, 2'd0, 0);
        add("gate_idle3",  1, 0, 0, 0, 1, 0,   0, 2'd0, 0);
        add("gate_b3",     1, 0, 0, 1, 1, 0,   0, 2'd0, 0);
        add("gate_b4",     1, 0, 0, 1, 1, 0,   1, 2'd1, 0);
        add("gate_drop",   1, 0, 0, 0, 1, 0,   0, 2'd1, 0);

        foreach (tbl[i]) begin
            step(tbl[i].rst_n, tbl[i].ld, tbl[i].ovl, tbl[i].vld, tbl[i].d, tbl[i].clr);
            check(tbl[i].name, tbl[i].e_out, tbl[i].e_cnt, tbl[i].e_sat);
        end

        // Saturation: 16 overlapping bits with matches on bits 4,7,10,13,16.
        sat_bits = 16'b1011011011011011;
        sat_hits = 16'b0001001001001001;
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 15; i >= 0; i--) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, sat_bits[i], 1'b0);
            n_total++;
            if (out === sat_hits[i]) n_pass++;
            else $display("FAIL sat_out_bit%0d: got %b want %b", 16 - i, out, sat_hits[i]);
        end
        check("sat_final", 1'b1, 2'd3, 1'b1);
        bit_in("sat_b17", 1'b0, 1'b0, 2'd3, 1'b1);
        bit_in("sat_b18", 1'b1, 1'b0, 2'd3, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("clr_vs_match", 1'b1, 2'd0, 1'b0);

        // Reset mid-stream: bits before reset must not complete a match.
        bit_in("rst_b1", 1'b1, 1'b0, 2'd0, 1'b0);
        bit_in("rst_b2", 1'b0, 1'b0, 2'd0, 1'b0);
        bit_in("rst_b3", 1'b1, 1'b0, 2'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("rst_mid", 1'b0, 2'd0, 1'b0);
        bit_in("rst_after", 1'b1, 1'b0, 2'd0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_reload", 1'b0, 2'd0, 1'b0);
        bit_in("rl_b1", 1'b1, 1'b0, 2'd0, 1'b0);
        bit_in("rl_b2", 1'b0, 1'b0, 2'd0, 1'b0);
        bit_in("rl_b3", 1'b1, 1'b0, 2'd0, 1'b0);
        bit_in("rl_b4", 1'b1, 1'b1, 2'd1, 1'b0);

        // Reconfig collision: din alongside cfg_load is dropped and history cleared.
        bit_in("col_b1", 1'b1, 1'b0, 2'd1, 1'b0);
        bit_in("col_b2", 1'b0, 1'b0, 2'd1, 1'b0);
        bit_in("col_b3", 1'b1, 1'b0, 2'd1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("col_load", 1'b0, 2'd1, 1'b0);
        bit_in("col_n1", 1'b1, 1'b0, 2'd1, 1'b0);
        bit_in("col_n2", 1'b0, 1'b0, 2'd1, 1'b0);
        bit_in("col_n3", 1'b1, 1'b0, 2'd1, 1'b0);
        bit_in("col_n4", 1'b1, 1'b1, 2'd2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
